// File: rtl/muldiv.sv
// Iterative 32-cycle multiply/divide unit owning the architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide run on operand magnitudes.
module muldiv (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [2:0]  mdc_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        busy_o,
  output logic [31:0] mul_result_o
);

  typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] ma_q, ma_d, mb_q, mb_d;
  logic [63:0] acc_q, acc_d;
  logic        sa_q, sa_d, sb_q, sb_d;
  logic        is_div_q, is_div_d, dz_q, dz_d;

  logic        start, signed_op, sa_new, sb_new;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum, div_trial;
  logic [63:0] step, prod;
  logic [31:0] quo, rem;

  assign start     = (mdc_i >= 3'd1) && (mdc_i <= 3'd4);
  assign signed_op = (mdc_i == 3'd1) || (mdc_i == 3'd3);
  assign sa_new    = signed_op & a_i[31];
  assign sb_new    = signed_op & b_i[31];
  assign a_mag     = sa_new ? -a_i : a_i;
  assign b_mag     = sb_new ? -b_i : b_i;

  // Multiply: acc = {partial product high, remaining multiplier bits}, shifted right each step.
  // Divide:   acc = {partial remainder, remaining dividend bits / quotient bits}, shifted left.
  always_comb begin
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, ma_q} : 33'd0);
    div_trial = {acc_q[63:32], acc_q[31]} - {1'b0, mb_q};
    if (is_div_q) begin
      step = div_trial[32] ? {acc_q[62:0], 1'b0} : {div_trial[31:0], acc_q[30:0], 1'b1};
    end else begin
      step = {mul_sum, acc_q[31:1]};
    end
    prod = (sa_q ^ sb_q) ? -step : step;
    quo  = (sa_q ^ sb_q) ? -step[31:0] : step[31:0];
    rem  = sa_q ? -step[63:32] : step[63:32];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    acc_d    = acc_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    is_div_d = is_div_q;
    dz_d     = dz_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          sa_d     = sa_new;
          sb_d     = sb_new;
          ma_d     = a_mag;
          mb_d     = b_mag;
          is_div_d = (mdc_i >= 3'd3);
          dz_d     = (b_i == 32'd0);
          acc_d    = (mdc_i >= 3'd3) ? {32'd0, a_mag} : {32'd0, b_mag};
          cnt_d    = 5'd0;
          state_d  = StRun;
        end else if (mdc_i == 3'd5) begin
          hi_d = a_i;
        end else if (mdc_i == 3'd6) begin
          lo_d = a_i;
        end
      end
      StRun: begin
        acc_d = step;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = StFinish;
          if (!is_div_q) begin
            hi_d = prod[63:32];
            lo_d = prod[31:0];
          end else if (dz_q) begin
            // Reconstruct the original dividend from its latched magnitude.
            lo_d = 32'hFFFF_FFFF;
            hi_d = sa_q ? -ma_q : ma_q;
          end else begin
            lo_d = quo;
            hi_d = rem;
          end
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= 5'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      ma_q     <= 32'd0;
      mb_q     <= 32'd0;
      acc_q    <= 64'd0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      is_div_q <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      ma_q     <= ma_d;
      mb_q     <= mb_d;
      acc_q    <= acc_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      is_div_q <= is_div_d;
      dz_q     <= dz_d;
    end
  end

  assign hi_o         = hi_q;
  assign lo_o         = lo_q;
  assign busy_o       = ((state_q == StIdle) && start) || (state_q == StRun);
  assign mul_result_o = a_i * b_i;

endmodule

// File: doc/muldiv.md
# muldiv

Multi-cycle multiply/divide unit for the single-cycle MIPS core. It sits next to the controller and consumes the controller's `mdc` code together with the rs/rt register-file read data. It owns the architectural HI/LO registers and runs mult/multu/div/divu iteratively over 32 cycles. While an iterative operation is in flight it asserts `busy`, which the top level uses to freeze the PC and block register-file writes.

## Interface
- No parameters. Data width is fixed at 32.
- `clk`  in  1  core clock; every register updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mdc`  in  3  operation code from the controller:
  - 0: none
  - 1: mult
  - 2: multu
  - 3: div
  - 4: divu
  - 5: mthi
  - 6: mtlo
  - 7: none
- `a`  in  32  rs read data (dividend / multiplicand / mthi-mtlo source).
- `b`  in  32  rt read data (divisor / multiplier).
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.
- `busy`  out  1  stall request to the PC and register-file write-enable logic.
- `mul_result`  out  32  combinational low 32 bits of signed `a*b`, used by the `mul` instruction. It does not depend on state and does not touch HI/LO.

## Operation
- States:
  - IDLE: accepts new operations.
  - RUN: one iteration per cycle, with a 5-bit counter.
  - FINISH: a single cycle during which the unit ignores `mdc`.
- IDLE, `mdc` in 1..4:
  - The unit latches operand magnitudes, the signs `sa = a[31]` and `sb = b[31]` (signed ops only; unsigned ops force both to 0), the op code, and a divide-by-zero flag (`b == 0`).
  - Counter is set to 0 and the state goes to RUN.
- IDLE, `mdc` = 5: `hi <= a` at the edge; the state stays IDLE.
- IDLE, `mdc` = 6: `lo <= a` at the edge; the state stays IDLE.
- IDLE, `mdc` = 0 or 7: no action.
- RUN, multiply: radix-2 shift-add on magnitudes into a 64-bit accumulator.
  - After iteration 31, the product is negated when `sa ^ sb` is set.
  - `{hi, lo}` is then written.
- RUN, divide: radix-2 restoring division on magnitudes, producing a quotient and remainder.
  - Quotient is negated when `sa ^ sb` is set.
  - Remainder is negated when `sa` is set.
  - `lo <= quotient`, `hi <= remainder`.
- Divide by zero (div or divu): the unit still runs the full 32 cycles, then writes `lo <= 32'hFFFFFFFF` and `hi <= ` the original `a`, ignoring sign correction.
- The final iteration, the sign correction and the HI/LO write all happen at the edge where counter == 31; the state then goes to FINISH.
- FINISH → IDLE at the next edge, unconditionally. `mdc` is ignored in FINISH, so the instruction still presented on the final stalled cycle is not re-accepted.
- In RUN and FINISH, `mdc` values 5/6 are ignored and HI/LO change only as described above.
- Arithmetic is modulo 2^32 per half. Negating 0x80000000 yields 0x80000000; for example div 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0.

## Timing
- Reset:
  - State IDLE, counter 0.
  - `hi` = 0, `lo` = 0, `busy` = 0, internal operand registers 0.
- `busy` is combinational: `(state == IDLE && mdc in 1..4) || state == RUN`.
  - It is high in the accept cycle, so the PC holds the instruction with no bubble.
- Latency from the accept cycle (cycle 0):
  - `busy` is high for cycles 0..32 (33 cycles).
  - HI/LO hold their new values from cycle 33 (FINISH), when `busy` = 0 and the PC advances.
  - The next instruction is seen in cycle 34 with the state back in IDLE.
- mthi/mtlo: zero stall; the new value is visible the cycle after.
- HI/LO keep their old values throughout RUN, so mfhi/mflo can never observe partial results because the PC is frozen.
- `rst` asserted in any state: the next edge forces the reset values, the in-flight result is discarded, and `busy` drops combinationally once the state is IDLE.
- `a`/`b` changing during RUN has no effect, because operands are latched at accept.

## Test plan
- Unsigned multiply: multu `a` = 0xFFFFFFFF, `b` = 0xFFFFFFFF → `busy` high for 33 cycles; then hi = 0xFFFFFFFE, lo = 0x00000001, `busy` = 0, and the unit returns to IDLE one cycle later.
- Signed multiply: mult `a` = 0xFFFFFFFD (-3), `b` = 5 → hi = 0xFFFFFFFF, lo = 0xFFFFFFF1. Repeat with mult 0x80000000 × 0x80000000 → hi = 0x40000000, lo = 0.
- Signed divide: div `a` = 0xFFFFFFF9 (-7), `b` = 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. Then divu `a` = 7, `b` = 0 → lo = 0xFFFFFFFF, hi = 7 after 33 busy cycles.
- Moves and hold-off:
  - mthi `a` = 0x12345678, then mtlo `a` = 0x9ABCDEF0 on consecutive cycles → both registers updated with `busy` = 0 throughout.
  - `mdc` held at 3 through FINISH → exactly one division is performed, not two.
- Reset mid-operation: start div `a` = 100, `b` = 7, assert `rst` in cycle 10 → hi = lo = 0 and `busy` = 0 the next cycle; a fresh div then yields lo = 14, hi = 2.
- `mul_result`: `a` = 0xFFFFFFFF, `b` = 3 → `mul_result` = 0xFFFFFFFD combinationally, with HI/LO and state unchanged.
